// File: rtl/i2c_slave_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_ctrl_multi
// Purpose  : I2C slave protocol engine. It has its own bit counter, shift
//            register and ACK/NACK generation. It matches up to NUM_ADDR
//            programmable 7-/10-bit addresses and stretches SCL on TX
//            underflow, with a bounded timeout.
// Ports    : clk/n_rst         - clock, async active-low reset
//            start_det/stop_det, scl_rise/scl_fall, SDA_sync
//                              - pulses and data from the bus synchroniser
//            address_mode, addr_en, slave_addr
//                              - address table (10 bits per entry)
//            tx_data/tx_empty  - show-ahead TX FIFO head; tx_read_enable pops
//            rx_full           - RX FIFO status; rx_write_enable/rx_data push
//            sda_drive_low/scl_hold
//                              - open-drain bus controls
//            busy, addr_idx, rw_mode, ack_error, stretch_timeout, byte_count
//                              - status
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_ctrl_multi #(
   parameter int NUM_ADDR        = 2,
   parameter int IDX_W           = 1,
   parameter int STRETCH_TIMEOUT = 255,
   parameter int CNT_W           = 8
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    start_det,
   input  logic                    stop_det,
   input  logic                    scl_rise,
   input  logic                    scl_fall,
   input  logic                    SDA_sync,
   input  logic                    address_mode,
   input  logic [NUM_ADDR-1:0]     addr_en,
   input  logic [10*NUM_ADDR-1:0]  slave_addr,
   input  logic [7:0]              tx_data,
   input  logic                    tx_empty,
   input  logic                    rx_full,
   output logic                    sda_drive_low,
   output logic                    scl_hold,
   output logic                    busy,
   output logic                    tx_read_enable,
   output logic                    rx_write_enable,
   output logic [7:0]              rx_data,
   output logic [IDX_W-1:0]        addr_idx,
   output logic                    rw_mode,
   output logic                    ack_error,
   output logic                    stretch_timeout,
   output logic [CNT_W-1:0]        byte_count
);

   localparam int c_TO_W = $clog2(STRETCH_TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_ADDR1   = 4'd1,
      S_ACK_A1  = 4'd2,
      S_ADDR2   = 4'd3,
      S_ACK_A2  = 4'd4,
      S_RX_DATA = 4'd5,
      S_RX_ACK  = 4'd6,
      S_TX_WAIT = 4'd7,
      S_TX_DATA = 4'd8,
      S_TX_ACK  = 4'd9,
      S_IGNORE  = 4'd10
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          bit_cnt_q, bit_cnt_d;
   logic [7:0]          shift_q, shift_d;
   logic                ack_q, ack_d;         // ACK to be driven in current slot
   logic [NUM_ADDR-1:0] cand_q, cand_d;       // 10-bit entries matching a9:a8
   logic                m10_q, m10_d;         // 10-bit write address matched
   logic [c_TO_W-1:0]   scnt_q, scnt_d;
   logic                sda_q, sda_d;
   logic                hold_q, hold_d;
   logic                busy_q, busy_d;
   logic                txre_q, txre_d;
   logic                rxwe_q, rxwe_d;
   logic [7:0]          rxd_q, rxd_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                rw_q, rw_d;
   logic                aerr_q, aerr_d;
   logic                sto_q, sto_d;
   logic [CNT_W-1:0]    bcnt_q, bcnt_d;

   // Byte as it stands including the bit being sampled on this scl_rise
   logic [7:0]          w_byte;
   logic                w_hit7, w_hit10;
   logic [IDX_W-1:0]    w_idx7, w_idx10;
   logic [NUM_ADDR-1:0] w_cand;
   logic                w_tx_enter;

   assign w_byte = {shift_q[6:0], SDA_sync};

   // Descending scan so the lowest matching index wins
   always_comb begin
      w_hit7  = 1'b0;
      w_idx7  = '0;
      w_hit10 = 1'b0;
      w_idx10 = '0;
      w_cand  = '0;
      for (int i = NUM_ADDR - 1; i >= 0; i--) begin
         if (addr_en[i] && (slave_addr[10*i +: 7] == w_byte[7:1])) begin
            w_hit7 = 1'b1;
            w_idx7 = IDX_W'(i);
         end
         if (addr_en[i] && (slave_addr[10*i+8 +: 2] == w_byte[2:1]))
            w_cand[i] = 1'b1;
         if (cand_q[i] && (slave_addr[10*i +: 8] == w_byte)) begin
            w_hit10 = 1'b1;
            w_idx10 = IDX_W'(i);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      ack_d      = ack_q;
      cand_d     = cand_q;
      m10_d      = m10_q;
      scnt_d     = scnt_q;
      sda_d      = sda_q;
      hold_d     = hold_q;
      busy_d     = busy_q;
      txre_d     = 1'b0;
      rxwe_d     = 1'b0;
      rxd_d      = rxd_q;
      idx_d      = idx_q;
      rw_d       = rw_q;
      aerr_d     = 1'b0;
      sto_d      = 1'b0;
      bcnt_d     = bcnt_q;
      w_tx_enter = 1'b0;

      case (state_q)
         S_ADDR1: if (scl_rise) begin
            shift_d   = w_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
               bit_cnt_d = '0;
               ack_d     = 1'b1;
               state_d   = S_IGNORE;
               if (!address_mode) begin
                  if (w_hit7) begin
                     idx_d   = w_idx7;
                     rw_d    = w_byte[0];
                     state_d = S_ACK_A2;
                  end
               end else if (w_byte[7:3] == 5'b11110) begin
                  if (!w_byte[0] && (|w_cand)) begin
                     cand_d  = w_cand;
                     m10_d   = 1'b0;
                     rw_d    = 1'b0;
                     state_d = S_ACK_A1;
                  end else if (w_byte[0] && m10_q) begin
                     rw_d    = 1'b1;
                     state_d = S_ACK_A2;
                  end
               end
            end
         end

         S_ADDR2: if (scl_rise) begin
            shift_d   = w_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
               bit_cnt_d = '0;
               ack_d     = 1'b1;
               if (w_hit10) begin
                  idx_d   = w_idx10;
                  m10_d   = 1'b1;
                  state_d = S_ACK_A2;
               end else begin
                  state_d = S_IGNORE;
               end
            end
         end

         S_RX_DATA: if (scl_rise) begin
            shift_d   = w_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
               bit_cnt_d = '0;
               ack_d     = !rx_full;
               state_d   = S_RX_ACK;
               if (!rx_full) begin
                  rxd_d  = w_byte;
                  rxwe_d = 1'b1;
                  if (bcnt_q != '1)
                     bcnt_d = bcnt_q + CNT_W'(1);
               end
            end
         end

         // First fall after the 8th rise opens the slot, the next one closes it
         S_ACK_A1, S_ACK_A2, S_RX_ACK: if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
               bit_cnt_d = 4'd1;
               sda_d     = ack_q;
            end else begin
               bit_cnt_d = '0;
               shift_d   = '0;
               sda_d     = 1'b0;
               if (state_q == S_ACK_A1)
                  state_d = S_ADDR2;
               else if ((state_q == S_ACK_A2) && rw_q)
                  w_tx_enter = 1'b1;
               else
                  state_d = S_RX_DATA;
            end
         end

         S_TX_WAIT: begin
            if (!tx_empty) begin
               txre_d    = 1'b1;
               shift_d   = tx_data;
               sda_d     = ~tx_data[7];
               hold_d    = 1'b0;
               bit_cnt_d = '0;
               state_d   = S_TX_DATA;
            end else if (int'(scnt_q) + 1 == STRETCH_TIMEOUT) begin
               hold_d  = 1'b0;
               sto_d   = 1'b1;
               state_d = S_IGNORE;
            end else begin
               scnt_d = scnt_q + c_TO_W'(1);
            end
         end

         S_TX_DATA: if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
               bit_cnt_d = '0;
               sda_d     = 1'b0;
               state_d   = S_TX_ACK;
               if (bcnt_q != '1)
                  bcnt_d = bcnt_q + CNT_W'(1);
            end else begin
               bit_cnt_d = bit_cnt_q + 4'd1;
               shift_d   = {shift_q[6:0], 1'b0};
               sda_d     = ~shift_q[6];
            end
         end

         // bit_cnt marks that the master's ACK has been seen
         S_TX_ACK: begin
            if (scl_rise) begin
               if (SDA_sync) begin
                  aerr_d  = 1'b1;
                  state_d = S_IGNORE;
               end else begin
                  bit_cnt_d = 4'd1;
               end
            end else if (scl_fall && (bit_cnt_q == 4'd1)) begin
               bit_cnt_d  = '0;
               w_tx_enter = 1'b1;
            end
         end

         S_IGNORE: begin
            sda_d  = 1'b0;
            hold_d = 1'b0;
         end

         default: ;
      endcase

      // End of an ACK slot in read direction: send at once or start stretching
      if (w_tx_enter) begin
         if (!tx_empty) begin
            txre_d    = 1'b1;
            shift_d   = tx_data;
            sda_d     = ~tx_data[7];
            bit_cnt_d = '0;
            state_d   = S_TX_DATA;
         end else begin
            sda_d   = 1'b0;
            hold_d  = 1'b1;
            scnt_d  = '0;
            state_d = S_TX_WAIT;
         end
      end

      if (start_det) begin
         state_d   = S_ADDR1;
         bit_cnt_d = '0;
         shift_d   = '0;
         busy_d    = 1'b1;
         sda_d     = 1'b0;
         hold_d    = 1'b0;
         // A repeated START after a 10-bit write match continues the transaction
         if (!m10_q)
            bcnt_d = '0;
      end else if (stop_det) begin
         state_d = S_IDLE;
         busy_d  = 1'b0;
         m10_d   = 1'b0;
         sda_d   = 1'b0;
         hold_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         ack_q     <= 1'b0;
         cand_q    <= '0;
         m10_q     <= 1'b0;
         scnt_q    <= '0;
         sda_q     <= 1'b0;
         hold_q    <= 1'b0;
         busy_q    <= 1'b0;
         txre_q    <= 1'b0;
         rxwe_q    <= 1'b0;
         rxd_q     <= '0;
         idx_q     <= '0;
         rw_q      <= 1'b0;
         aerr_q    <= 1'b0;
         sto_q     <= 1'b0;
         bcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         ack_q     <= ack_d;
         cand_q    <= cand_d;
         m10_q     <= m10_d;
         scnt_q    <= scnt_d;
         sda_q     <= sda_d;
         hold_q    <= hold_d;
         busy_q    <= busy_d;
         txre_q    <= txre_d;
         rxwe_q    <= rxwe_d;
         rxd_q     <= rxd_d;
         idx_q     <= idx_d;
         rw_q      <= rw_d;
         aerr_q    <= aerr_d;
         sto_q     <= sto_d;
         bcnt_q    <= bcnt_d;
      end
   end

   assign sda_drive_low   = sda_q;
   assign scl_hold        = hold_q;
   assign busy            = busy_q;
   assign tx_read_enable  = txre_q;
   assign rx_write_enable = rxwe_q;
   assign rx_data         = rxd_q;
   assign addr_idx        = idx_q;
   assign rw_mode         = rw_q;
   assign ack_error       = aerr_q;
   assign stretch_timeout = sto_q;
   assign byte_count      = bcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_ctrl_multi
// Purpose  : Self-checking bench for i2c_slave_ctrl_multi. A bus-level master
//            model drives bit pulses; received bytes are scoreboarded through
//            a queue, and strobes are counted by a negedge monitor.
//            A second instance with STRETCH_TIMEOUT=4 covers the abort path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_ctrl_multi;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        start_det = 1'b0, stop_det = 1'b0;
   logic        scl_rise = 1'b0, scl_fall = 1'b0;
   logic        sda_m = 1'b1;
   logic        sda_sync;
   logic        address_mode = 1'b0;
   logic [1:0]  addr_en = 2'b11;
   logic [19:0] slave_addr = {10'h02A, 10'h011};
   logic [7:0]  tx_data = 8'h00;
   logic        tx_empty = 1'b1;
   logic        rx_full = 1'b0;

   logic       sda_drive_low, scl_hold, busy, tx_read_enable, rx_write_enable;
   logic [7:0] rx_data;
   logic [0:0] addr_idx;
   logic       rw_mode, ack_error, stretch_timeout;
   logic [7:0] byte_count;

   logic       t_sda, t_hold, t_busy, t_txre, t_rxwe, t_rw, t_aerr, t_sto;
   logic [7:0] t_rxd, t_bcnt;
   logic [0:0] t_idx;

   // Wired-AND bus: master drives sda_m, slave pulls low
   assign sda_sync = sda_m & ~sda_drive_low;

   always #5 clk = ~clk;

   i2c_slave_ctrl_multi #(.NUM_ADDR(2), .IDX_W(1), .STRETCH_TIMEOUT(255), .CNT_W(8)) u_dut (
      .clk(clk), .n_rst(n_rst), .start_det(start_det), .stop_det(stop_det),
      .scl_rise(scl_rise), .scl_fall(scl_fall), .SDA_sync(sda_sync),
      .address_mode(address_mode), .addr_en(addr_en), .slave_addr(slave_addr),
      .tx_data(tx_data), .tx_empty(tx_empty), .rx_full(rx_full),
      .sda_drive_low(sda_drive_low), .scl_hold(scl_hold), .busy(busy),
      .tx_read_enable(tx_read_enable), .rx_write_enable(rx_write_enable),
      .rx_data(rx_data), .addr_idx(addr_idx), .rw_mode(rw_mode),
      .ack_error(ack_error), .stretch_timeout(stretch_timeout), .byte_count(byte_count)
   );

   i2c_slave_ctrl_multi #(.NUM_ADDR(2), .IDX_W(1), .STRETCH_TIMEOUT(4), .CNT_W(8)) u_dut_to (
      .clk(clk), .n_rst(n_rst), .start_det(start_det), .stop_det(stop_det),
      .scl_rise(scl_rise), .scl_fall(scl_fall), .SDA_sync(sda_sync),
      .address_mode(address_mode), .addr_en(addr_en), .slave_addr(slave_addr),
      .tx_data(tx_data), .tx_empty(tx_empty), .rx_full(rx_full),
      .sda_drive_low(t_sda), .scl_hold(t_hold), .busy(t_busy),
      .tx_read_enable(t_txre), .rx_write_enable(t_rxwe),
      .rx_data(t_rxd), .addr_idx(t_idx), .rw_mode(t_rw),
      .ack_error(t_aerr), .stretch_timeout(t_sto), .byte_count(t_bcnt)
   );

   int n_vec = 0, n_err = 0;
   int n_rxwe = 0, n_txre = 0, n_aerr = 0, n_sto = 0, n_hold = 0, n_sda = 0;
   int n_t_hold = 0, n_t_sto = 0, n_t_txre = 0;
   logic [7:0] rx_exp_q[$];
   logic [7:0] tx_exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor: pop the scoreboard on every RX push, count other strobes
   always @(negedge clk) begin
      if (n_rst) begin
         if (rx_write_enable) begin
            check_eq("rx_push_expected", 32'(rx_exp_q.size() != 0), 32'd1);
            if (rx_exp_q.size() != 0)
               check_eq("rx_data", {24'd0, rx_data}, {24'd0, rx_exp_q.pop_front()});
            n_rxwe++;
         end
         if (tx_read_enable)  n_txre++;
         if (ack_error)       n_aerr++;
         if (stretch_timeout) n_sto++;
         if (scl_hold)        n_hold++;
         if (sda_drive_low)   n_sda++;
         if (t_hold)          n_t_hold++;
         if (t_sto)           n_t_sto++;
         if (t_txre)          n_t_txre++;
      end
   end

   task automatic clk_tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_rise();
      scl_rise = 1'b1; clk_tick(); scl_rise = 1'b0; clk_tick(); clk_tick();
   endtask

   task automatic do_fall();
      scl_fall = 1'b1; clk_tick(); scl_fall = 1'b0; clk_tick(); clk_tick();
   endtask

   task automatic do_start();
      start_det = 1'b1; clk_tick(); start_det = 1'b0; clk_tick();
      do_fall();
   endtask

   task automatic do_stop();
      stop_det = 1'b1; clk_tick(); stop_det = 1'b0; clk_tick(); clk_tick();
   endtask

   // Master writes a byte; ack = slave pulled SDA low in the ACK slot
   task automatic send_byte(input logic [7:0] b, input logic chk_rel, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         sda_m = b[i];
         do_rise();
         do_fall();
      end
      ack   = sda_drive_low;
      sda_m = 1'b1;
      do_rise();
      do_fall();
      if (chk_rel)
         check_eq("ack_released", {31'd0, sda_drive_low}, 32'd0);
   endtask

   // Master reads a byte, then ACKs (mack=1) or NACKs
   task automatic recv_byte(input logic mack, output logic [7:0] b);
      int w;
      w = 0;
      while (scl_hold && w < 300) begin
         clk_tick();
         w++;
      end
      if (scl_hold)
         check_eq("hold_wait_timeout", {31'd0, scl_hold}, 32'd0);
      sda_m = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         b[i] = sda_sync;
         do_rise();
         do_fall();
      end
      sda_m = ~mack;
      do_rise();
      do_fall();
      sda_m = 1'b1;
   endtask

   initial begin
      logic       ack;
      logic [7:0] b;
      int         s0, s1, s2, s3, k;

      // Reset state
      #2;
      check_eq("reset_outputs", {7'd0, sda_drive_low, scl_hold, busy, tx_read_enable,
               rx_write_enable, rx_data, addr_idx, rw_mode, ack_error, stretch_timeout,
               byte_count}, 32'd0);
      clk_tick(); clk_tick();
      n_rst = 1'b1;
      clk_tick();

      // 7-bit write to entry1 (0x2A)
      do_start();
      check_eq("t1_busy", {31'd0, busy}, 32'd1);
      s0 = n_rxwe;
      send_byte(8'h54, 1'b1, ack);
      check_eq("t1_addr_ack", {31'd0, ack}, 32'd1);
      check_eq("t1_addr_idx", {31'd0, addr_idx}, 32'd1);
      check_eq("t1_rw", {31'd0, rw_mode}, 32'd0);
      rx_exp_q.push_back(8'hA5);
      send_byte(8'hA5, 1'b1, ack);
      check_eq("t1_d0_ack", {31'd0, ack}, 32'd1);
      rx_exp_q.push_back(8'h3C);
      send_byte(8'h3C, 1'b1, ack);
      check_eq("t1_d1_ack", {31'd0, ack}, 32'd1);
      check_eq("t1_byte_count", {24'd0, byte_count}, 32'd2);
      check_eq("t1_rx_pushes", n_rxwe - s0, 2);
      do_stop();
      check_eq("t1_busy_after_stop", {31'd0, busy}, 32'd0);

      // Unmatched 7-bit address 0x55
      s0 = n_sda; s1 = n_rxwe; s2 = n_txre;
      do_start();
      send_byte(8'hAA, 1'b1, ack);
      check_eq("t2_addr_nack", {31'd0, ack}, 32'd0);
      send_byte(8'h5A, 1'b1, ack);
      check_eq("t2_data_nack", {31'd0, ack}, 32'd0);
      check_eq("t2_sda_never", n_sda - s0, 0);
      check_eq("t2_no_rx", n_rxwe - s1, 0);
      check_eq("t2_no_tx", n_txre - s2, 0);
      do_stop();

      // 10-bit write header then repeated-START read, entry0 = 0x2C7
      address_mode = 1'b1;
      slave_addr = {10'h02A, 10'h2C7};
      s0 = n_txre; s1 = n_aerr;
      do_start();
      send_byte(8'hF4, 1'b1, ack);
      check_eq("t3_hdr_ack", {31'd0, ack}, 32'd1);
      send_byte(8'hC7, 1'b1, ack);
      check_eq("t3_a2_ack", {31'd0, ack}, 32'd1);
      check_eq("t3_addr_idx", {31'd0, addr_idx}, 32'd0);
      tx_data = 8'h81; tx_empty = 1'b0;
      tx_exp_q.push_back(8'h81);
      do_start();
      send_byte(8'hF5, 1'b0, ack);
      tx_empty = 1'b1;
      check_eq("t3_rd_ack", {31'd0, ack}, 32'd1);
      check_eq("t3_rw", {31'd0, rw_mode}, 32'd1);
      check_eq("t3_tx_pop", n_txre - s0, 1);
      recv_byte(1'b0, b);
      check_eq("t3_tx_byte", {24'd0, b}, {24'd0, tx_exp_q.pop_front()});
      check_eq("t3_ack_error", n_aerr - s1, 1);
      check_eq("t3_byte_count", {24'd0, byte_count}, 32'd1);
      do_stop();

      // TX underflow: stretch for 10 cycles, then data arrives
      address_mode = 1'b0;
      tx_empty = 1'b1;
      s0 = n_hold; s1 = n_aerr;
      do_start();
      send_byte(8'h55, 1'b0, ack);
      check_eq("t4_rd_ack", {31'd0, ack}, 32'd1);
      repeat (7) clk_tick();
      tx_data = 8'h3C; tx_empty = 1'b0;
      tx_exp_q.push_back(8'h3C);
      k = 0;
      while (!tx_read_enable && k < 20) begin
         clk_tick();
         k++;
      end
      check_eq("t4_tx_pop_seen", {31'd0, tx_read_enable}, 32'd1);
      check_eq("t4_hold_drop_same", {31'd0, scl_hold}, 32'd0);
      tx_empty = 1'b1;
      check_eq("t4_hold_cycles", n_hold - s0, 10);
      recv_byte(1'b1, b);
      check_eq("t4_tx_byte", {24'd0, b}, {24'd0, tx_exp_q.pop_front()});
      check_eq("t4_no_ack_error", n_aerr - s1, 0);
      check_eq("t4_byte_count", {24'd0, byte_count}, 32'd1);
      check_eq("t4_stretch_again", {31'd0, scl_hold}, 32'd1);
      do_stop();
      check_eq("t4_hold_after_stop", {31'd0, scl_hold}, 32'd0);

      // Stretch timeout on the STRETCH_TIMEOUT=4 instance
      s0 = n_t_hold; s1 = n_t_sto; s2 = n_sto; s3 = n_t_txre;
      do_start();
      send_byte(8'h55, 1'b0, ack);
      repeat (10) clk_tick();
      check_eq("t5_hold_cycles", n_t_hold - s0, 4);
      check_eq("t5_timeout_pulse", n_t_sto - s1, 1);
      check_eq("t5_hold_released", {31'd0, t_hold}, 32'd0);
      check_eq("t5_sda_released", {31'd0, t_sda}, 32'd0);
      check_eq("t5_long_no_timeout", n_sto - s2, 0);
      tx_data = 8'h99; tx_empty = 1'b0;
      repeat (3) clk_tick();
      tx_empty = 1'b1;
      check_eq("t5_ignore_no_pop", n_t_txre - s3, 0);
      do_stop();

      // rx_full on the second data byte, then async reset mid-byte
      slave_addr = {10'h02A, 10'h011};
      s0 = n_rxwe;
      do_start();
      send_byte(8'h22, 1'b1, ack);
      check_eq("t6_addr_idx", {31'd0, addr_idx}, 32'd0);
      rx_exp_q.push_back(8'h12);
      send_byte(8'h12, 1'b1, ack);
      check_eq("t6_d0_ack", {31'd0, ack}, 32'd1);
      rx_full = 1'b1;
      send_byte(8'h34, 1'b1, ack);
      check_eq("t6_d1_nack", {31'd0, ack}, 32'd0);
      check_eq("t6_rx_pushes", n_rxwe - s0, 1);
      check_eq("t6_byte_count", {24'd0, byte_count}, 32'd1);
      rx_full = 1'b0;
      sda_m = 1'b1; do_rise(); do_fall();
      sda_m = 1'b0; do_rise();
      #2;
      n_rst = 1'b0;
      #1;
      check_eq("t6_async_reset", {7'd0, sda_drive_low, scl_hold, busy, tx_read_enable,
               rx_write_enable, rx_data, addr_idx, rw_mode, ack_error, stretch_timeout,
               byte_count}, 32'd0);
      check_eq("t6_async_reset_to", {7'd0, t_sda, t_hold, t_busy, t_txre, t_rxwe, t_rxd,
               t_idx, t_rw, t_aerr, t_sto, t_bcnt}, 32'd0);
      clk_tick();
      n_rst = 1'b1;
      clk_tick();
      check_eq("rx_scoreboard_empty", rx_exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
